instr_decode: RTL and testbench
===============================

# instr_decode

ID stage of the veriRISCV 5-stage RV32I pipeline, directly downstream of instruction fetch. It decodes the instruction presented on the if2id bus, reads operands from an internal 32x32 register file with write-back bypass, generates the immediate and control signals, and registers everything onto the id2ex bus for the execute stage. The register file write port is driven by the write-back stage.

## Interface
- XLEN, 32, data and PC width
- REG_ADDR_W, 5, register index width
---
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if2id_pc  in  XLEN  PC of the fetched instruction
- if2id_instruction  in  XLEN  fetched instruction word
- id_stall  in  1  hold all id2ex registers
- id_flush  in  1  load a bubble into id2ex
- wb_reg_write  in  1  register file write enable
- wb_rd_addr  in  REG_ADDR_W  write index
- wb_rd_data  in  XLEN  write data
- id2ex_pc  out  XLEN  registered PC
- id2ex_rs1_data, id2ex_rs2_data  out  XLEN  operand values
- id2ex_imm  out  XLEN  sign-extended immediate
- id2ex_rs1_addr, id2ex_rs2_addr, id2ex_rd_addr  out  REG_ADDR_W  register indices (for hazard/forward logic)
- id2ex_funct3  out  3  instr[14:12]
- id2ex_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- id2ex_alu_src_imm  out  1  ALU operand B = imm
- id2ex_alu_src_pc  out  1  ALU operand A = PC
- id2ex_reg_write, id2ex_mem_read, id2ex_mem_write  out  1  each
- id2ex_branch, id2ex_jal, id2ex_jalr  out  1  each
- id2ex_illegal  out  1  unsupported opcode/funct

## Operation
- Decode purely combinational from if2id_instruction; results captured into id2ex registers.
- Immediate: I (OP-IMM, LOAD, JALR), S, B, U, J formats, all sign-extended from instr[31]; R-type imm = 0.
- OP/OP-IMM: alu_op from funct3 (+ instr[30] for SUB/SRA; SUB only for OP). SLLI/SRLI/SRAI with illegal funct7 -> illegal.
- LOAD: ADD, src_imm, mem_read, reg_write. STORE: ADD, src_imm, mem_write. BRANCH: branch=1, SUB, funct3 passed through; funct3 010/011 -> illegal.
- LUI: PASSB, src_imm, reg_write. AUIPC: ADD, src_pc, src_imm, reg_write.
- JAL: jal, reg_write, src_pc, src_imm. JALR: jalr, reg_write, src_imm.
- Any other opcode (or instr[1:0] != 11): illegal=1, all other control bits 0.
- reg_write forced 0 when rd = x0.
- Register file: 32 entries, async read, write at posedge when wb_reg_write && wb_rd_addr != 0. x0 reads 0 always. All entries cleared on rst.
- Bypass: if wb_reg_write && wb_rd_addr == rsN && rsN != 0, rsN_data = wb_rd_data (same-cycle write-through).

## Timing
- Latency: 1 cycle, if2id inputs -> id2ex outputs at next posedge.
- Reset: every id2ex output = 0 (bubble, alu_op ADD) on the edge rst is sampled high; register file zeroed same edge. Reset mid-stream discards in-flight decode.
- Priority per edge: rst > id_flush > id_stall > normal load.
- id_flush: all id2ex control bits (reg_write, mem_*, branch, jal, jalr, illegal) = 0; data fields may be 0.
- id_stall: id2ex registers unchanged; register file write still performed. Operand data held stale; execute-stage forwarding resolves it.
- Flush and stall same cycle: flush wins.
- Write-back to rd and read of same rd in same cycle: bypassed value registered.

## Test plan
- Reset then addi x1,x0,5 (0x00500093), pc 0x0: next edge id2ex_imm=5, rd=1, rs1_data=0, ADD, src_imm=1, reg_write=1; prior cycle all outputs 0.
- wb writes x1=0x11, x2=0x22; then add x3,x1,x2 (0x002081B3): rs1_data=0x11, rs2_data=0x22, alu_op=ADD, src_imm=0; repeat with x2 written in same cycle as decode -> bypassed value seen.
- sw x2,8(x1) (0x0020A423): mem_write=1, reg_write=0, imm=8; beq x0,x0,-4 (0xFE000EE3): branch=1, imm=0xFFFFFFFC.
- lui x5,0x12345 (0x123452B7): imm=0x12345000, PASSB, reg_write=1; write wb x0=0xFF then read x0 -> 0.
- id_stall for 2 cycles with new instruction present: outputs hold; id_flush with stall -> all control 0 next edge.
- Word 0x00000000 and opcode 0x7F: illegal=1, all other control 0; rst asserted mid-sequence clears outputs and register file.

Source files
------------

// File: rtl/instr_decode_if.sv
// IF->ID->EX pipeline bus for the decode stage: fetch inputs, stall/flush,
// write-back port and the registered id2ex outputs.
interface instr_decode_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic [XLEN-1:0]       if2id_pc;
    logic [XLEN-1:0]       if2id_instruction;
    logic                  id_stall;
    logic                  id_flush;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic [XLEN-1:0]       wb_rd_data;

    logic [XLEN-1:0]       id2ex_pc;
    logic [XLEN-1:0]       id2ex_rs1_data;
    logic [XLEN-1:0]       id2ex_rs2_data;
    logic [XLEN-1:0]       id2ex_imm;
    logic [REG_ADDR_W-1:0] id2ex_rs1_addr;
    logic [REG_ADDR_W-1:0] id2ex_rs2_addr;
    logic [REG_ADDR_W-1:0] id2ex_rd_addr;
    logic [2:0]            id2ex_funct3;
    logic [3:0]            id2ex_alu_op;
    logic                  id2ex_alu_src_imm;
    logic                  id2ex_alu_src_pc;
    logic                  id2ex_reg_write;
    logic                  id2ex_mem_read;
    logic                  id2ex_mem_write;
    logic                  id2ex_branch;
    logic                  id2ex_jal;
    logic                  id2ex_jalr;
    logic                  id2ex_illegal;

    modport master (
        output if2id_pc, if2id_instruction, id_stall, id_flush,
               wb_reg_write, wb_rd_addr, wb_rd_data,
        input  id2ex_pc, id2ex_rs1_data, id2ex_rs2_data, id2ex_imm,
               id2ex_rs1_addr, id2ex_rs2_addr, id2ex_rd_addr, id2ex_funct3,
               id2ex_alu_op, id2ex_alu_src_imm, id2ex_alu_src_pc,
               id2ex_reg_write, id2ex_mem_read, id2ex_mem_write,
               id2ex_branch, id2ex_jal, id2ex_jalr, id2ex_illegal
    );

    modport slave (
        input  if2id_pc, if2id_instruction, id_stall, id_flush,
               wb_reg_write, wb_rd_addr, wb_rd_data,
        output id2ex_pc, id2ex_rs1_data, id2ex_rs2_data, id2ex_imm,
               id2ex_rs1_addr, id2ex_rs2_addr, id2ex_rd_addr, id2ex_funct3,
               id2ex_alu_op, id2ex_alu_src_imm, id2ex_alu_src_pc,
               id2ex_reg_write, id2ex_mem_read, id2ex_mem_write,
               id2ex_branch, id2ex_jal, id2ex_jalr, id2ex_illegal
    );
endinterface

// File: rtl/instr_decode.sv
// RV32I decode stage: combinational decode, 32x32 register file with
// write-back bypass, and the id2ex pipeline register.
module instr_decode #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic           clk,
    input logic           rst,
    instr_decode_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [XLEN-1:0]       ins;
    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;

    assign ins    = bus.if2id_instruction;
    assign opcode = ins[6:0];
    assign funct7 = ins[31:25];
    assign funct3 = ins[14:12];
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];
    assign rd     = ins[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [XLEN-1:0] d_imm;
    logic [3:0]      d_alu_op;
    logic            d_src_imm, d_src_pc, d_reg_write, d_mem_read, d_mem_write;
    logic            d_branch, d_jal, d_jalr, d_illegal;

    always_comb begin
        d_imm       = '0;
        d_alu_op    = ALU_ADD;
        d_src_imm   = 1'b0;
        d_src_pc    = 1'b0;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_branch    = 1'b0;
        d_jal       = 1'b0;
        d_jalr      = 1'b0;
        d_illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_reg_write = 1'b1;
                d_alu_op    = alu_from_funct3(funct3, ins[30]);
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    d_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                d_imm       = imm_i;
                d_src_imm   = 1'b1;
                d_reg_write = 1'b1;
                // instr[30] only selects SRA for immediates; ADDI never becomes SUB
                d_alu_op    = alu_from_funct3(funct3, funct3 == 3'b101 && ins[30]);
                if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                    (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000))
                    d_illegal = 1'b1;
            end
            OPC_LOAD: begin
                d_imm       = imm_i;
                d_src_imm   = 1'b1;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_STORE: begin
                d_imm       = imm_s;
                d_src_imm   = 1'b1;
                d_mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                d_imm     = imm_b;
                d_alu_op  = ALU_SUB;
                d_branch  = 1'b1;
                d_illegal = (funct3 == 3'b010 || funct3 == 3'b011);
            end
            OPC_LUI: begin
                d_imm       = imm_u;
                d_alu_op    = ALU_PASSB;
                d_src_imm   = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                d_imm       = imm_u;
                d_src_imm   = 1'b1;
                d_src_pc    = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_JAL: begin
                d_imm       = imm_j;
                d_jal       = 1'b1;
                d_src_imm   = 1'b1;
                d_src_pc    = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_JALR: begin
                d_imm       = imm_i;
                d_jalr      = 1'b1;
                d_src_imm   = 1'b1;
                d_reg_write = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_alu_op    = ALU_ADD;
            d_src_imm   = 1'b0;
            d_src_pc    = 1'b0;
            d_reg_write = 1'b0;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            d_branch    = 1'b0;
            d_jal       = 1'b0;
            d_jalr      = 1'b0;
        end
        if (rd == '0)
            d_reg_write = 1'b0;
    end

    logic [XLEN-1:0] regs [0:31];
    logic [XLEN-1:0] rs1_val, rs2_val;

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '{default: '0};
        else if (bus.wb_reg_write && bus.wb_rd_addr != '0)
            regs[bus.wb_rd_addr] <= bus.wb_rd_data;
    end

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0)
            rs1_val = (bus.wb_reg_write && bus.wb_rd_addr == rs1) ? bus.wb_rd_data : regs[rs1];
        if (rs2 != '0)
            rs2_val = (bus.wb_reg_write && bus.wb_rd_addr == rs2) ? bus.wb_rd_data : regs[rs2];
    end

    // Flush loads a full bubble (data fields zeroed too), which also covers flush+stall
    always_ff @(posedge clk) begin
        if (rst || bus.id_flush) begin
            bus.id2ex_pc          <= '0;
            bus.id2ex_rs1_data    <= '0;
            bus.id2ex_rs2_data    <= '0;
            bus.id2ex_imm         <= '0;
            bus.id2ex_rs1_addr    <= '0;
            bus.id2ex_rs2_addr    <= '0;
            bus.id2ex_rd_addr     <= '0;
            bus.id2ex_funct3      <= '0;
            bus.id2ex_alu_op      <= ALU_ADD;
            bus.id2ex_alu_src_imm <= 1'b0;
            bus.id2ex_alu_src_pc  <= 1'b0;
            bus.id2ex_reg_write   <= 1'b0;
            bus.id2ex_mem_read    <= 1'b0;
            bus.id2ex_mem_write   <= 1'b0;
            bus.id2ex_branch      <= 1'b0;
            bus.id2ex_jal         <= 1'b0;
            bus.id2ex_jalr        <= 1'b0;
            bus.id2ex_illegal     <= 1'b0;
        end else if (!bus.id_stall) begin
            bus.id2ex_pc          <= bus.if2id_pc;
            bus.id2ex_rs1_data    <= rs1_val;
            bus.id2ex_rs2_data    <= rs2_val;
            bus.id2ex_imm         <= d_imm;
            bus.id2ex_rs1_addr    <= rs1;
            bus.id2ex_rs2_addr    <= rs2;
            bus.id2ex_rd_addr     <= rd;
            bus.id2ex_funct3      <= funct3;
            bus.id2ex_alu_op      <= d_alu_op;
            bus.id2ex_alu_src_imm <= d_src_imm;
            bus.id2ex_alu_src_pc  <= d_src_pc;
            bus.id2ex_reg_write   <= d_reg_write;
            bus.id2ex_mem_read    <= d_mem_read;
            bus.id2ex_mem_write   <= d_mem_write;
            bus.id2ex_branch      <= d_branch;
            bus.id2ex_jal         <= d_jal;
            bus.id2ex_jalr        <= d_jalr;
            bus.id2ex_illegal     <= d_illegal;
        end
    end
endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: directed instructions with hand-decoded
// expected id2ex contents, checked by an independent negedge monitor.
module tb_instr_decode;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_decode_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
    instr_decode #(.XLEN(32), .REG_ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        simm;
        logic        spc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ill;
    } vec_t;

    typedef struct {
        int    at;
        string name;
        vec_t  v;
    } item_t;

    item_t q[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t actual();
        vec_t a;
        a.pc   = bus.id2ex_pc;        a.rs1d = bus.id2ex_rs1_data;
        a.rs2d = bus.id2ex_rs2_data;  a.imm  = bus.id2ex_imm;
        a.rs1a = bus.id2ex_rs1_addr;  a.rs2a = bus.id2ex_rs2_addr;
        a.rda  = bus.id2ex_rd_addr;   a.f3   = bus.id2ex_funct3;
        a.alu  = bus.id2ex_alu_op;    a.simm = bus.id2ex_alu_src_imm;
        a.spc  = bus.id2ex_alu_src_pc; a.rw  = bus.id2ex_reg_write;
        a.mr   = bus.id2ex_mem_read;  a.mw   = bus.id2ex_mem_write;
        a.br   = bus.id2ex_branch;    a.jal  = bus.id2ex_jal;
        a.jalr = bus.id2ex_jalr;      a.ill  = bus.id2ex_illegal;
        return a;
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            item_t it;
            vec_t  a;
            it = q.pop_front();
            a = actual();
            checks++;
            if (a !== it.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, a, it.v);
            end
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic stall, input logic flush,
                         input logic wbw, input logic [4:0] wba, input logic [31:0] wbd);
        bus.if2id_pc          = pc;
        bus.if2id_instruction = instr;
        bus.id_stall          = stall;
        bus.id_flush          = flush;
        bus.wb_reg_write      = wbw;
        bus.wb_rd_addr        = wba;
        bus.wb_rd_data        = wbd;
    endtask

    task automatic step(input string name, input vec_t v);
        item_t it;
        it.at = cyc + 1;
        it.name = name;
        it.v = v;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e, held;

        rst = 1'b1;
        drive(32'h0, 32'h00500093, 0, 0, 0, 5'd0, 32'h0);
        e = '0;
        step("reset", e);

        rst = 1'b0;
        e = '0; e.imm = 32'd5; e.rs2a = 5'd5; e.rda = 5'd1; e.simm = 1; e.rw = 1;
        step("addi_x1", e);

        drive(32'h4, 32'h00000013, 0, 0, 1, 5'd1, 32'h11);
        e = '0; e.pc = 32'h4; e.simm = 1;
        step("nop_rd0", e);

        drive(32'h8, 32'h00000013, 0, 0, 1, 5'd2, 32'h22);
        e.pc = 32'h8;
        step("nop_wb_x2", e);

        drive(32'hC, 32'h002081B3, 0, 0, 0, 5'd0, 32'h0);
        e = '0; e.pc = 32'hC; e.rs1d = 32'h11; e.rs2d = 32'h22;
        e.rs1a = 5'd1; e.rs2a = 5'd2; e.rda = 5'd3; e.rw = 1;
        step("add_regs", e);

        drive(32'h10, 32'h002081B3, 0, 0, 1, 5'd2, 32'h55);
        e.pc = 32'h10; e.rs2d = 32'h55;
        step("add_bypass", e);

        drive(32'h14, 32'h0020A423, 0, 0, 0, 5'd0, 32'h0);
        e = '0; e.pc = 32'h14; e.rs1d = 32'h11; e.rs2d = 32'h55; e.imm = 32'd8;
        e.rs1a = 5'd1; e.rs2a = 5'd2; e.rda = 5'd8; e.f3 = 3'd2; e.simm = 1; e.mw = 1;
        step("sw", e);

        drive(32'h18, 32'hFE000EE3, 0, 0, 0, 5'd0, 32'h0);
        e = '0; e.pc = 32'h18; e.imm = 32'hFFFFFFFC; e.rda = 5'd29; e.alu = 4'd1; e.br = 1;
        step("beq", e);

        drive(32'h1C, 32'h123452B7, 0, 0, 0, 5'd0, 32'h0);
        e = '0; e.pc = 32'h1C; e.imm = 32'h12345000; e.rs1a = 5'd8; e.rs2a = 5'd3;
        e.rda = 5'd5; e.f3 = 3'd5; e.alu = 4'd10; e.simm = 1; e.rw = 1;
        step("lui", e);

        drive(32'h20, 32'h00000233, 0, 0, 1, 5'd0, 32'hFF);
        e = '0; e.pc = 32'h20; e.rda = 5'd4; e.rw = 1;
        step("x0_wb_same", e);

        drive(32'h24, 32'h00000233, 0, 0, 0, 5'd0, 32'h0);
        e.pc = 32'h24;
        held = e;
        step("x0_read", e);

        drive(32'h28, 32'h123452B7, 1, 0, 1, 5'd6, 32'h66);
        step("stall1", held);
        drive(32'h2C, 32'h0020A423, 1, 0, 0, 5'd0, 32'h0);
        step("stall2", held);

        drive(32'h2C, 32'h0020A423, 1, 1, 0, 5'd0, 32'h0);
        e = '0;
        step("flush_stall", e);

        drive(32'h30, 32'h00000000, 0, 0, 0, 5'd0, 32'h0);
        e = '0; e.pc = 32'h30; e.ill = 1;
        step("illegal_zero", e);

        drive(32'h34, 32'h0000007F, 0, 0, 0, 5'd0, 32'h0);
        e.pc = 32'h34;
        step("illegal_7f", e);

        drive(32'h38, 32'h002081B3, 0, 0, 0, 5'd0, 32'h0);
        e = '0; e.pc = 32'h38; e.rs1d = 32'h11; e.rs2d = 32'h55;
        e.rs1a = 5'd1; e.rs2a = 5'd2; e.rda = 5'd3; e.rw = 1;
        step("add_pre_rst", e);

        rst = 1'b1;
        e = '0;
        step("mid_reset", e);

        rst = 1'b0;
        drive(32'h3C, 32'h002081B3, 0, 0, 0, 5'd0, 32'h0);
        e = '0; e.pc = 32'h3C; e.rs1a = 5'd1; e.rs2a = 5'd2; e.rda = 5'd3; e.rw = 1;
        step("add_post_rst", e);

        drive(32'h40, 32'h402081B3, 0, 0, 0, 5'd0, 32'h0);
        e.pc = 32'h40; e.alu = 4'd1;
        step("sub", e);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
